// File: rtl/jtag_axi_txn_engine.sv
// jtag_axi_txn_engine: pops one JTAG request, runs a single-beat AXI4 read/write, pushes status back.
// Optional watchdog enabled by defining JTAG_AXI_TIMEOUT_EN.
package jtag_axi_pkg;
   typedef logic [31:0] axi_addr_t;
   typedef logic [31:0] axi_data_t;
   typedef logic [3:0]  axi_wr_strb_t;
   typedef logic [3:0]  axi_id_t;
   typedef enum logic [1:0] {JTAG_OKAY, JTAG_EXOKAY, JTAG_SLVERR, JTAG_DECERR} jtag_resp_t;
   typedef struct packed {
      logic       txn_type;
      logic [2:0] size;
      axi_addr_t  addr;
   } s_axi_afifo_to_axi_t;
   typedef struct packed {
      jtag_resp_t status;
      axi_data_t  data_rd;
   } s_axi_jtag_status_t;
   typedef struct packed {
      axi_id_t      awid;
      axi_addr_t    awaddr;
      logic [7:0]   awlen;
      logic [2:0]   awsize;
      logic [1:0]   awburst;
      logic         awvalid;
      axi_data_t    wdata;
      axi_wr_strb_t wstrb;
      logic         wlast;
      logic         wvalid;
      logic         bready;
      axi_id_t      arid;
      axi_addr_t    araddr;
      logic [7:0]   arlen;
      logic [2:0]   arsize;
      logic [1:0]   arburst;
      logic         arvalid;
      logic         rready;
   } s_axi_mosi_t;
   typedef struct packed {
      logic       awready;
      logic       wready;
      logic [1:0] bresp;
      logic       bvalid;
      logic       arready;
      axi_data_t  rdata;
      logic [1:0] rresp;
      logic       rvalid;
   } s_axi_miso_t;
endpackage

module jtag_axi_txn_engine
   import jtag_axi_pkg::*;
#(
   parameter int AXI_MASTER_ID  = 0,
   parameter int AXI_TIMEOUT_CC = 4096
) (
   input  logic                clk,
   input  logic                ares,
   input  logic                fifo_rd_txn_empty,
   input  s_axi_afifo_to_axi_t fifo_rd_txn,
   output logic                fifo_rd_en,
   input  logic                fifo_wr_data_txn_empty,
   input  axi_data_t           fifo_wr_data,
   input  axi_wr_strb_t        fifo_wr_strb,
   output logic                fifo_wr_data_en,
   input  logic                fifo_wr_txn_full,
   output s_axi_jtag_status_t  fifo_wr_resp,
   output logic                fifo_wr_en,
   output logic                timeout_o,
   output s_axi_mosi_t         jtag_axi_mosi_o,
   input  s_axi_miso_t         jtag_axi_miso_i
);
   typedef enum logic [2:0] {ST_IDLE, ST_WR_REQ, ST_WR_RESP, ST_RD_REQ, ST_RD_RESP, ST_PUSH} state_t;
   state_t       state, state_n;
   axi_addr_t    addr_q;
   logic [2:0]   size_q;
   axi_data_t    wdata_q, rdata_q;
   axi_wr_strb_t wstrb_q;
   jtag_resp_t   resp_q;
   logic         aw_done, w_done, timeout_q, start, is_wr;
   logic         aw_v, w_v, ar_v, b_r, r_r, aw_hs, w_hs, ar_hs, b_hs, r_hs;
   assign is_wr = fifo_rd_txn.txn_type;
   // a write only starts once its data beat is already waiting
   assign start = state == ST_IDLE && !ares && !fifo_rd_txn_empty && !fifo_wr_txn_full && !timeout_q &&
                  (!is_wr || !fifo_wr_data_txn_empty);
   assign aw_v  = state == ST_WR_REQ && !aw_done;
   assign w_v   = state == ST_WR_REQ && !w_done;
   assign ar_v  = state == ST_RD_REQ;
   assign b_r   = state == ST_WR_RESP;
   assign r_r   = state == ST_RD_RESP;
   assign aw_hs = aw_v && jtag_axi_miso_i.awready;
   assign w_hs  = w_v && jtag_axi_miso_i.wready;
   assign ar_hs = ar_v && jtag_axi_miso_i.arready;
   assign b_hs  = b_r && jtag_axi_miso_i.bvalid;
   assign r_hs  = r_r && jtag_axi_miso_i.rvalid;
   assign timeout_o    = timeout_q;
   assign fifo_wr_resp = '{status: resp_q, data_rd: rdata_q};
   always_ff @(posedge clk or posedge ares)
      if (ares) begin
         state   <= ST_IDLE;
         addr_q  <= '0;
         size_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         rdata_q <= '0;
         resp_q  <= JTAG_OKAY;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         state <= state_n;
         if (start) begin
            addr_q  <= fifo_rd_txn.addr;
            size_q  <= fifo_rd_txn.size;
            wdata_q <= fifo_wr_data;
            wstrb_q <= fifo_wr_strb;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end
         if (aw_hs) aw_done <= 1'b1;
         if (w_hs) w_done <= 1'b1;
         if (b_hs) begin
            resp_q  <= jtag_resp_t'(jtag_axi_miso_i.bresp);
            rdata_q <= '0;
         end
         if (r_hs) begin
            resp_q  <= jtag_resp_t'(jtag_axi_miso_i.rresp);
            rdata_q <= jtag_axi_miso_i.rdata;
         end
      end
   always_comb begin
      state_n         = state;
      fifo_rd_en      = 1'b0;
      fifo_wr_data_en = 1'b0;
      fifo_wr_en      = 1'b0;
      unique case (state)
         ST_IDLE: if (start) begin
            fifo_rd_en      = 1'b1;
            fifo_wr_data_en = is_wr;
            state_n         = is_wr ? ST_WR_REQ : ST_RD_REQ;
         end
         ST_WR_REQ:  if ((aw_done || aw_hs) && (w_done || w_hs)) state_n = ST_WR_RESP;
         ST_WR_RESP: if (b_hs) state_n = timeout_q ? ST_IDLE : ST_PUSH;
         ST_RD_REQ:  if (ar_hs) state_n = ST_RD_RESP;
         ST_RD_RESP: if (r_hs) state_n = timeout_q ? ST_IDLE : ST_PUSH;
         ST_PUSH: if (!fifo_wr_txn_full) begin
            fifo_wr_en = 1'b1;
            state_n    = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end
   always_comb begin
      jtag_axi_mosi_o         = '0;
      jtag_axi_mosi_o.awid    = axi_id_t'(AXI_MASTER_ID);
      jtag_axi_mosi_o.awaddr  = addr_q;
      jtag_axi_mosi_o.awsize  = size_q;
      jtag_axi_mosi_o.awburst = 2'b01;
      jtag_axi_mosi_o.awvalid = aw_v;
      jtag_axi_mosi_o.wdata   = wdata_q;
      jtag_axi_mosi_o.wstrb   = wstrb_q;
      jtag_axi_mosi_o.wlast   = 1'b1;
      jtag_axi_mosi_o.wvalid  = w_v;
      jtag_axi_mosi_o.bready  = b_r;
      jtag_axi_mosi_o.arid    = axi_id_t'(AXI_MASTER_ID);
      jtag_axi_mosi_o.araddr  = addr_q;
      jtag_axi_mosi_o.arsize  = size_q;
      jtag_axi_mosi_o.arburst = 2'b01;
      jtag_axi_mosi_o.arvalid = ar_v;
      jtag_axi_mosi_o.rready  = r_r;
   end
`ifdef JTAG_AXI_TIMEOUT_EN
   localparam int CW = $clog2(AXI_TIMEOUT_CC + 1);
   logic [CW-1:0] cnt;
   logic          busy;
   assign busy = state inside {ST_WR_REQ, ST_WR_RESP, ST_RD_REQ, ST_RD_RESP};
   // counter freezes once the flag is up; the flag clears only on reset
   always_ff @(posedge clk or posedge ares)
      if (ares) begin
         cnt       <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (start) cnt <= '0;
         else if (busy && !timeout_q) cnt <= cnt + 1'b1;
         if (busy && cnt == CW'(AXI_TIMEOUT_CC - 1)) timeout_q <= 1'b1;
      end
`else
   // watchdog compiled out: flag is constant 0
   assign timeout_q = AXI_TIMEOUT_CC < 0;
`endif
endmodule

// File: tb/tb_jtag_axi_txn_engine.sv
// tb_jtag_axi_txn_engine: directed scenarios against a small AXI slave model and hand-driven FIFO heads.
// The timeout scenario checks the watchdog when JTAG_AXI_TIMEOUT_EN is defined, otherwise an endless wait.
module tb_jtag_axi_txn_engine;
   import jtag_axi_pkg::*;
   localparam int MID = 5;
   logic clk = 1'b0;
   logic ares = 1'b1;
   logic fifo_rd_txn_empty = 1'b1, fifo_wr_data_txn_empty = 1'b1, fifo_wr_txn_full = 1'b0;
   logic fifo_rd_en, fifo_wr_data_en, fifo_wr_en, timeout_o;
   s_axi_afifo_to_axi_t fifo_rd_txn = '0;
   axi_data_t fifo_wr_data = '0;
   axi_wr_strb_t fifo_wr_strb = '0;
   s_axi_jtag_status_t fifo_wr_resp;
   s_axi_mosi_t mosi;
   s_axi_miso_t miso;
   int checks = 0, errors = 0;
   int aw_stall = 0;
   logic ar_en = 1'b1;
   logic [1:0] bresp_val = 2'b00, rresp_val = 2'b00;
   axi_data_t rdata_val = '0;
   int aw_hi;
   logic aw_got, w_got, bvalid_q, rvalid_q;
   axi_data_t rdata_q;
   logic [1:0] rresp_q;
   logic aw_hs, w_hs, ar_hs;
   int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, push_cnt = 0, pop_cnt = 0, awv_cnt = 0, wv_cnt = 0;
   s_axi_mosi_t aw_cap = '0, w_cap = '0, ar_cap = '0;

   always #5 clk = ~clk;

   jtag_axi_txn_engine #(.AXI_MASTER_ID(MID), .AXI_TIMEOUT_CC(16)) dut (
      .clk(clk), .ares(ares),
      .fifo_rd_txn_empty(fifo_rd_txn_empty), .fifo_rd_txn(fifo_rd_txn), .fifo_rd_en(fifo_rd_en),
      .fifo_wr_data_txn_empty(fifo_wr_data_txn_empty), .fifo_wr_data(fifo_wr_data),
      .fifo_wr_strb(fifo_wr_strb), .fifo_wr_data_en(fifo_wr_data_en),
      .fifo_wr_txn_full(fifo_wr_txn_full), .fifo_wr_resp(fifo_wr_resp), .fifo_wr_en(fifo_wr_en),
      .timeout_o(timeout_o), .jtag_axi_mosi_o(mosi), .jtag_axi_miso_i(miso)
   );

   assign aw_hs = mosi.awvalid && miso.awready;
   assign w_hs  = mosi.wvalid && miso.wready;
   assign ar_hs = mosi.arvalid && miso.arready;

   always_comb begin
      miso         = '0;
      miso.awready = mosi.awvalid && aw_hi >= aw_stall;
      miso.wready  = 1'b1;
      miso.bvalid  = bvalid_q;
      miso.bresp   = bresp_val;
      miso.arready = ar_en;
      miso.rvalid  = rvalid_q;
      miso.rdata   = rdata_q;
      miso.rresp   = rresp_q;
   end

   // slave: B one cycle after both AW and W seen, R one cycle after AR
   always @(posedge clk or posedge ares)
      if (ares) begin
         aw_hi <= 0; aw_got <= 1'b0; w_got <= 1'b0;
         bvalid_q <= 1'b0; rvalid_q <= 1'b0; rdata_q <= '0; rresp_q <= '0;
      end else begin
         aw_hi <= (mosi.awvalid && !miso.awready) ? aw_hi + 1 : 0;
         if (bvalid_q && mosi.bready) bvalid_q <= 1'b0;
         if ((aw_got || aw_hs) && (w_got || w_hs)) begin
            bvalid_q <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
         end else begin
            if (aw_hs) aw_got <= 1'b1;
            if (w_hs) w_got <= 1'b1;
         end
         if (ar_hs) begin
            rvalid_q <= 1'b1; rdata_q <= rdata_val; rresp_q <= rresp_val;
         end else if (rvalid_q && mosi.rready) rvalid_q <= 1'b0;
      end

   always @(posedge clk) begin
      if (aw_hs) begin aw_cnt <= aw_cnt + 1; aw_cap <= mosi; end
      if (w_hs) begin w_cnt <= w_cnt + 1; w_cap <= mosi; end
      if (ar_hs) begin ar_cnt <= ar_cnt + 1; ar_cap <= mosi; end
      if (mosi.awvalid) awv_cnt <= awv_cnt + 1;
      if (mosi.wvalid) wv_cnt <= wv_cnt + 1;
      if (fifo_wr_en) push_cnt <= push_cnt + 1;
      if (fifo_rd_en) pop_cnt <= pop_cnt + 1;
   end

   task automatic post(input logic wr, input axi_addr_t a, input axi_data_t d, input axi_wr_strb_t s,
                       input logic wd_ready);
      fifo_rd_txn = '{txn_type: wr, size: 3'd2, addr: a};
      fifo_wr_data = d;
      fifo_wr_strb = s;
      fifo_rd_txn_empty = 1'b0;
      fifo_wr_data_txn_empty = !(wr && wd_ready);
   endtask

   // n = negedges until the pop was seen (-1 if never); returns just after the popping edge
   task automatic wait_pop(output int n, output logic wd_pop);
      n = -1; wd_pop = 1'b0;
      for (int i = 1; i <= 200 && n < 0; i++) begin
         @(negedge clk);
         if (fifo_rd_en) begin n = i; wd_pop = fifo_wr_data_en; end
      end
      @(posedge clk); #1;
      fifo_rd_txn_empty = 1'b1;
      if (wd_pop) fifo_wr_data_txn_empty = 1'b1;
   endtask

   task automatic wait_push(input int lim, output int n, output s_axi_jtag_status_t r);
      n = -1; r = '0;
      for (int i = 1; i <= lim && n < 0; i++) begin
         @(negedge clk);
         if (fifo_wr_en) begin n = i; r = fifo_wr_resp; end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      post(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      repeat (3) @(negedge clk);
      checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b exp 0", fifo_rd_en); end
      checks++; if (fifo_wr_en !== 1'b0 || fifo_wr_data_en !== 1'b0) begin errors++; $display("FAIL reset_en got %b%b exp 00", fifo_wr_en, fifo_wr_data_en); end
      checks++; if (fifo_wr_resp !== '0) begin errors++; $display("FAIL reset_resp got %h exp 0", fifo_wr_resp); end
      checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", timeout_o); end
      checks++; if ({mosi.awvalid, mosi.wvalid, mosi.arvalid, mosi.bready, mosi.rready} !== 5'b0) begin
         errors++; $display("FAIL reset_bus got %b exp 00000", {mosi.awvalid, mosi.wvalid, mosi.arvalid, mosi.bready, mosi.rready});
      end
      fifo_rd_txn_empty = 1'b1;
      @(posedge clk); #1 ares = 1'b0;
   endtask

   task automatic test_write;
      int n, aw0, w0, p0;
      logic wdp;
      s_axi_jtag_status_t r;
      aw0 = aw_cnt; w0 = w_cnt; p0 = push_cnt;
      bresp_val = 2'b00;
      post(1'b1, 32'h1000, 32'hDEADBEEF, 4'hF, 1'b1);
      wait_pop(n, wdp);
      checks++; if (n != 1 || wdp !== 1'b1) begin errors++; $display("FAIL wr_pop got n=%0d wd=%b exp n=1 wd=1", n, wdp); end
      @(negedge clk);
      checks++; if ({mosi.awvalid, mosi.wvalid} !== 2'b11) begin errors++; $display("FAIL wr_valid_latency got %b exp 11", {mosi.awvalid, mosi.wvalid}); end
      wait_push(20, n, r);
      checks++; if (n < 0 || r.status !== JTAG_OKAY || r.data_rd !== 32'h0) begin errors++; $display("FAIL wr_push got n=%0d st=%0d d=%h exp OKAY 0", n, r.status, r.data_rd); end
      checks++; if (aw_cnt - aw0 != 1 || w_cnt - w0 != 1 || push_cnt - p0 != 1) begin
         errors++; $display("FAIL wr_beats got aw=%0d w=%0d push=%0d exp 1 1 1", aw_cnt - aw0, w_cnt - w0, push_cnt - p0);
      end
      checks++; if (aw_cap.awaddr !== 32'h1000 || aw_cap.awlen !== 8'd0 || aw_cap.awburst !== 2'b01 || aw_cap.awsize !== 3'd2) begin
         errors++; $display("FAIL wr_aw got a=%h len=%h b=%b s=%0d exp 1000 0 01 2", aw_cap.awaddr, aw_cap.awlen, aw_cap.awburst, aw_cap.awsize);
      end
      checks++; if (aw_cap.awid !== 4'(MID)) begin errors++; $display("FAIL wr_awid got %0d exp %0d", aw_cap.awid, MID); end
      checks++; if (w_cap.wdata !== 32'hDEADBEEF || w_cap.wstrb !== 4'hF || w_cap.wlast !== 1'b1) begin
         errors++; $display("FAIL wr_w got d=%h s=%h l=%b exp deadbeef f 1", w_cap.wdata, w_cap.wstrb, w_cap.wlast);
      end
   endtask

   task automatic test_read;
      int n;
      logic wdp;
      s_axi_jtag_status_t r;
      rdata_val = 32'hCAFEF00D; rresp_val = 2'b10; ar_en = 1'b1;
      post(1'b0, 32'h2000, 32'h0, 4'h0, 1'b0);
      wait_pop(n, wdp);
      checks++; if (n != 1 || wdp !== 1'b0) begin errors++; $display("FAIL rd_pop got n=%0d wd=%b exp n=1 wd=0", n, wdp); end
      wait_push(20, n, r);
      checks++; if (n != 3) begin errors++; $display("FAIL rd_latency got %0d exp 3", n); end
      checks++; if (r.status !== JTAG_SLVERR || r.data_rd !== 32'hCAFEF00D) begin errors++; $display("FAIL rd_push got st=%0d d=%h exp SLVERR cafef00d", r.status, r.data_rd); end
      checks++; if (ar_cap.araddr !== 32'h2000 || ar_cap.arlen !== 8'd0 || ar_cap.arburst !== 2'b01 || ar_cap.arid !== 4'(MID)) begin
         errors++; $display("FAIL rd_ar got a=%h len=%h b=%b id=%0d exp 2000 0 01 %0d", ar_cap.araddr, ar_cap.arlen, ar_cap.arburst, ar_cap.arid, MID);
      end
   endtask

   task automatic test_aw_stall;
      int n, awv0, wv0, p0;
      logic wdp;
      s_axi_jtag_status_t r;
      awv0 = awv_cnt; wv0 = wv_cnt; p0 = push_cnt;
      aw_stall = 4; bresp_val = 2'b01;
      post(1'b1, 32'h3004, 32'h0BADF00D, 4'h3, 1'b1);
      wait_pop(n, wdp);
      wait_push(40, n, r);
      aw_stall = 0;
      checks++; if (awv_cnt - awv0 != 5) begin errors++; $display("FAIL stall_awvalid_cycles got %0d exp 5", awv_cnt - awv0); end
      checks++; if (wv_cnt - wv0 != 1) begin errors++; $display("FAIL stall_wvalid_cycles got %0d exp 1", wv_cnt - wv0); end
      checks++; if (push_cnt - p0 != 1 || r.status !== JTAG_EXOKAY) begin errors++; $display("FAIL stall_push got cnt=%0d st=%0d exp 1 EXOKAY", push_cnt - p0, r.status); end
      checks++; if (w_cap.wstrb !== 4'h3 || aw_cap.awaddr !== 32'h3004) begin errors++; $display("FAIL stall_cap got s=%h a=%h exp 3 3004", w_cap.wstrb, aw_cap.awaddr); end
   endtask

   task automatic test_wdata_wait;
      int n, act, p0;
      logic wdp;
      s_axi_jtag_status_t r;
      bresp_val = 2'b00; p0 = pop_cnt; act = 0;
      post(1'b1, 32'h4000, 32'h11223344, 4'hF, 1'b0);
      repeat (10) begin
         @(negedge clk);
         if (fifo_rd_en || fifo_wr_data_en || mosi.awvalid || mosi.wvalid || mosi.arvalid) act++;
      end
      checks++; if (act != 0 || pop_cnt != p0) begin errors++; $display("FAIL wdwait_idle got act=%0d pops=%0d exp 0 0", act, pop_cnt - p0); end
      @(posedge clk); #1 fifo_wr_data_txn_empty = 1'b0;
      wait_pop(n, wdp);
      checks++; if (n != 1 || wdp !== 1'b1) begin errors++; $display("FAIL wdwait_pop got n=%0d wd=%b exp 1 1", n, wdp); end
      wait_push(20, n, r);
      checks++; if (r.status !== JTAG_OKAY || w_cap.wdata !== 32'h11223344) begin errors++; $display("FAIL wdwait_data got st=%0d d=%h exp OKAY 11223344", r.status, w_cap.wdata); end
   endtask

   task automatic test_resp_full;
      int n, act, p0, u0;
      logic wdp;
      s_axi_jtag_status_t r;
      rdata_val = 32'h55AA0FF0; rresp_val = 2'b00;
      post(1'b0, 32'h5000, 32'h0, 4'h0, 1'b0);
      wait_pop(n, wdp);
      fifo_wr_txn_full = 1'b1;
      post(1'b0, 32'h6000, 32'h0, 4'h0, 1'b0);
      p0 = pop_cnt; u0 = push_cnt; act = 0;
      repeat (20) begin
         @(negedge clk);
         if (fifo_wr_en || fifo_rd_en) act++;
      end
      checks++; if (act != 0 || pop_cnt != p0 || push_cnt != u0) begin errors++; $display("FAIL full_stall got act=%0d pops=%0d push=%0d exp 0 0 0", act, pop_cnt - p0, push_cnt - u0); end
      @(posedge clk); #1 fifo_wr_txn_full = 1'b0;
      wait_push(5, n, r);
      checks++; if (n != 1 || r.data_rd !== 32'h55AA0FF0 || r.status !== JTAG_OKAY) begin errors++; $display("FAIL full_push got n=%0d d=%h st=%0d exp 1 55aa0ff0 OKAY", n, r.data_rd, r.status); end
      rdata_val = 32'h60000001;
      wait_pop(n, wdp);
      checks++; if (n != 1) begin errors++; $display("FAIL full_next_pop got %0d exp 1", n); end
      wait_push(20, n, r);
      checks++; if (r.data_rd !== 32'h60000001 || ar_cap.araddr !== 32'h6000) begin errors++; $display("FAIL full_second got d=%h a=%h exp 60000001 6000", r.data_rd, ar_cap.araddr); end
   endtask

   task automatic test_back_to_back;
      int n;
      logic wdp;
      s_axi_jtag_status_t r;
      bresp_val = 2'b11; rresp_val = 2'b01; rdata_val = 32'h0F0F1234;
      post(1'b1, 32'h7000, 32'hA5A55A5A, 4'hC, 1'b1);
      wait_pop(n, wdp);
      post(1'b0, 32'h7100, 32'h0, 4'h0, 1'b0);
      wait_push(20, n, r);
      checks++; if (r.status !== JTAG_DECERR || r.data_rd !== 32'h0) begin errors++; $display("FAIL b2b_wr got st=%0d d=%h exp DECERR 0", r.status, r.data_rd); end
      wait_pop(n, wdp);
      checks++; if (n != 1) begin errors++; $display("FAIL b2b_pop got %0d exp 1", n); end
      wait_push(20, n, r);
      checks++; if (r.status !== JTAG_EXOKAY || r.data_rd !== 32'h0F0F1234) begin errors++; $display("FAIL b2b_rd got st=%0d d=%h exp EXOKAY 0f0f1234", r.status, r.data_rd); end
   endtask

   task automatic test_async_reset;
      int n;
      logic wdp;
      s_axi_jtag_status_t r;
      aw_stall = 100; bresp_val = 2'b00;
      post(1'b1, 32'h8000, 32'h12345678, 4'hF, 1'b1);
      wait_pop(n, wdp);
      repeat (3) @(negedge clk);
      checks++; if (mosi.awvalid !== 1'b1) begin errors++; $display("FAIL arst_before got %b exp 1", mosi.awvalid); end
      #2 ares = 1'b1;
      #1;
      checks++; if ({mosi.awvalid, mosi.wvalid, mosi.bready, fifo_wr_en} !== 4'b0 || fifo_wr_resp !== '0) begin
         errors++; $display("FAIL arst_clear got v=%b resp=%h exp 0000 0", {mosi.awvalid, mosi.wvalid, mosi.bready, fifo_wr_en}, fifo_wr_resp);
      end
      aw_stall = 0;
      @(posedge clk); #1 ares = 1'b0;
      rdata_val = 32'h88880008; rresp_val = 2'b00;
      post(1'b0, 32'h8800, 32'h0, 4'h0, 1'b0);
      wait_pop(n, wdp);
      wait_push(20, n, r);
      checks++; if (n != 3 || r.data_rd !== 32'h88880008) begin errors++; $display("FAIL arst_recover got n=%0d d=%h exp 3 88880008", n, r.data_rd); end
   endtask

   task automatic test_timeout;
      int n, p0, u0, a0, act;
      logic wdp;
      s_axi_jtag_status_t r;
      ar_en = 1'b0; rdata_val = 32'h77770007; rresp_val = 2'b00;
      post(1'b0, 32'h9000, 32'h0, 4'h0, 1'b0);
      wait_pop(n, wdp);
      u0 = push_cnt;
`ifdef JTAG_AXI_TIMEOUT_EN
      n = -1;
      for (int i = 1; i <= 40 && n < 0; i++) begin
         @(negedge clk);
         if (timeout_o) n = i;
      end
      checks++; if (n != 17) begin errors++; $display("FAIL to_rise got %0d exp 17", n); end
      p0 = pop_cnt; a0 = ar_cnt;
      post(1'b0, 32'h9100, 32'h0, 4'h0, 1'b0);
      repeat (10) @(negedge clk);
      checks++; if (mosi.arvalid !== 1'b1) begin errors++; $display("FAIL to_arvalid_held got %b exp 1", mosi.arvalid); end
      ar_en = 1'b1;
      repeat (10) @(negedge clk);
      checks++; if (push_cnt != u0 || pop_cnt != p0 || ar_cnt - a0 != 1) begin
         errors++; $display("FAIL to_drain got push=%0d pop=%0d ar=%0d exp 0 0 1", push_cnt - u0, pop_cnt - p0, ar_cnt - a0);
      end
      checks++; if (timeout_o !== 1'b1 || miso.rvalid !== 1'b0) begin errors++; $display("FAIL to_sticky got t=%b rv=%b exp 1 0", timeout_o, miso.rvalid); end
      fifo_rd_txn_empty = 1'b1;
      ares = 1'b1;
      #1;
      checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL to_reset got %b exp 0", timeout_o); end
      @(posedge clk); #1 ares = 1'b0;
`else
      act = 0; p0 = pop_cnt; a0 = ar_cnt;
      repeat (40) begin
         @(negedge clk);
         if (timeout_o !== 1'b0 || mosi.arvalid !== 1'b1) act++;
      end
      checks++; if (act != 0 || push_cnt != u0 || ar_cnt != a0) begin errors++; $display("FAIL nowd_wait got act=%0d push=%0d ar=%0d exp 0 0 0", act, push_cnt - u0, ar_cnt - a0); end
      ar_en = 1'b1;
      wait_push(10, n, r);
      checks++; if (n < 0 || r.data_rd !== 32'h77770007 || pop_cnt != p0) begin errors++; $display("FAIL nowd_push got n=%0d d=%h pops=%0d exp >0 77770007 0", n, r.data_rd, pop_cnt - p0); end
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got hang exp finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      test_reset;
      test_write;
      test_read;
      test_aw_stall;
      test_wdata_wait;
      test_resp_full;
      test_back_to_back;
      test_async_reset;
      test_timeout;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
